ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Multi-key PS/2 set-2 scancode tracker; successor of the single-key lab7 tracker.
//  Pops bytes from the ps2 receiver FIFO (ready/nextdata_n), parses E0/F0 prefixes,
//  keeps up to NSLOT held keys, counts new presses, flags press/release events.
//  Sits between ps2 and the ps2_decoder/seg display path in top.
// PARAMETERS
//  NSLOT  4  number of simultaneously tracked held keys (1..8)
//  CNT_W  8  width of press_count; wraps modulo 2^CNT_W
// PORTS
//  clk          in   1        system clock, all logic posedge
//  clrn         in   1        reset, asynchronous, active-high
//  ps2_data     in   8        FIFO head byte from ps2
//  ps2_ready    in   1        FIFO non-empty
//  nextdata_n   out  1        low for 1 cycle = pop head byte
//  press_evt    out  1        1-cycle pulse: new key press
//  release_evt  out  1        1-cycle pulse: held key released
//  repeat_evt   out  1        1-cycle pulse: typematic repeat (see CONFIGURATION)
//  last_code    out  9        {ext,code} of most recent press/release
//  held_codes   out  9*NSLOT  slot i at [9i+8:9i], {ext,code}
//  held_valid   out  NSLOT    slot occupied mask
//  press_count  out  CNT_W    count of new presses
//  drop_flag    out  1        sticky: make dropped because all slots full
// BEHAVIOUR
//  Reset: nextdata_n=1, all pulses 0, last_code=0, held_codes=0, held_valid=0,
//   press_count=0, drop_flag=0, FSM=IDLE. Async; clears mid-sequence, prefixes lost.
//  Pop: cycle T ps2_ready=1 and pop_gap=0 -> byte sampled, nextdata_n=0 in T+1,
//   nextdata_n=1 in T+2 (gap cycle, no pop). Max 1 byte per 2 cycles.
//  Events/outputs update at T+2 (latency 2 from sample edge); pulses 1 cycle.
//  FSM (ext bit E, prefix state):
//   IDLE: E0->EXT; F0->BRK(E=0); E1,AA,FA,EE,00,FF discarded; else MAKE(E=0).
//   EXT:  F0->BRK(E=1); E0 stays EXT; else MAKE(E=1), ->IDLE.
//   BRK:  any byte b -> RELEASE({E,b}), ->IDLE (E0/F0 inside BRK -> IDLE, no event).
//  MAKE(k): k held -> repeat only (no count, no press_evt); else lowest free slot
//   gets k, held_valid set, press_evt=1, press_count+1, last_code=k;
//   no free slot -> discarded, drop_flag=1 (cleared only by clrn).
//  RELEASE(k): k held -> slot cleared (code=0,valid=0), release_evt=1, last_code=k;
//   not held -> ignored silently. Other slots never move (no compaction).
//  press_count wraps 2^CNT_W-1 -> 0. Held compare includes ext bit (E0 75 != 75).
//  ps2_ready deasserting during gap: no pop; overflow in ps2 is not handled here.
// CONFIGURATION
//  PS2_TRK_REPEAT_EN defined: MAKE of already-held k pulses repeat_evt and sets
//   last_code=k. Undefined: repeat_evt tied 0, repeats have no visible effect.
// TESTING
//  Bytes 1C,F0,1C -> press_evt(1C), count=1, slot0=01C; release_evt, held_valid=0.
//  1C,1C,1C,F0,1C -> one press_evt, count=1; REPEAT_EN: 2 repeat_evt else none.
//  E0,75,F0,75 -> press 175 held; F0,75 release of 075 ignored; E0,F0,75 frees it.
//  NSLOT=4: makes 1C,32,21,23,2B -> 4 slots valid, drop_flag=1, count=4; F0,32
//   frees slot1, make 2B -> lands slot1.
//  CNT_W=4: 16 distinct press/release pairs -> press_count 15 -> 0.
//  clrn pulse after E0,F0 mid-sequence -> all outputs 0; next 1C = plain make 01C.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// Multi-key PS/2 set-2 scancode tracker: pops FIFO bytes, parses E0/F0 prefixes, tracks held keys.
// Optional macro PS2_TRK_REPEAT_EN makes typematic repeats visible on repeat_evt/last_code.
module ps2_key_tracker #(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [7:0]           ps2_data,
    input  logic                 ps2_ready,
    output logic                 nextdata_n,
    output logic                 press_evt,
    output logic                 release_evt,
    output logic                 repeat_evt,
    output logic [8:0]           last_code,
    output logic [9*NSLOT-1:0]   held_codes,
    output logic [NSLOT-1:0]     held_valid,
    output logic [CNT_W-1:0]     press_count,
    output logic                 drop_flag
);

    typedef enum logic [1:0] {StIdle, StExt, StBrk} state_t;

    state_t     state;
    logic       ext;
    logic [7:0] byte_q;
    logic       byte_vld;
    logic [8:0] slot [NSLOT];

    logic [8:0]       key;
    logic [NSLOT-1:0] hit;
    logic [NSLOT-1:0] free;
    logic             found;
    logic             is_prefix;
    logic             is_discard;
    logic             do_make;
    logic             do_rel;

    always_comb begin
        key        = {ext, byte_q};
        hit        = '0;
        free       = '0;
        found      = 1'b0;
        is_prefix  = (byte_q == 8'hE0) || (byte_q == 8'hF0);
        is_discard = (byte_q == 8'hE1) || (byte_q == 8'hAA) || (byte_q == 8'hFA) ||
                     (byte_q == 8'hEE) || (byte_q == 8'h00) || (byte_q == 8'hFF);
        for (int i = 0; i < int'(NSLOT); i++) begin
            hit[i] = held_valid[i] && (slot[i] == key);
            if (!held_valid[i] && !found) begin
                free[i] = 1'b1;
                found   = 1'b1;
            end
        end
        do_make = 1'b0;
        do_rel  = 1'b0;
        if (byte_vld) begin
            unique case (state)
                StIdle:  do_make = !is_prefix && !is_discard;
                StExt:   do_make = !is_prefix;
                StBrk:   do_rel  = !is_prefix;
                default: ;
            endcase
        end
    end

    always_comb begin
        held_codes = '0;
        for (int i = 0; i < int'(NSLOT); i++) begin
            held_codes[9*i +: 9] = slot[i];
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state       <= StIdle;
            ext         <= 1'b0;
            byte_q      <= 8'h00;
            byte_vld    <= 1'b0;
            nextdata_n  <= 1'b1;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
`ifdef PS2_TRK_REPEAT_EN
            repeat_evt  <= 1'b0;
`endif
            last_code   <= '0;
            held_valid  <= '0;
            press_count <= '0;
            drop_flag   <= 1'b0;
            for (int i = 0; i < int'(NSLOT); i++) slot[i] <= '0;
        end else begin
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
`ifdef PS2_TRK_REPEAT_EN
            repeat_evt  <= 1'b0;
`endif
            // nextdata_n low doubles as the gap cycle after each pop
            if (nextdata_n && ps2_ready) begin
                byte_q     <= ps2_data;
                byte_vld   <= 1'b1;
                nextdata_n <= 1'b0;
            end else begin
                byte_vld   <= 1'b0;
                nextdata_n <= 1'b1;
            end

            if (byte_vld) begin
                unique case (state)
                    StIdle: begin
                        if (byte_q == 8'hE0) begin
                            state <= StExt;
                            ext   <= 1'b1;
                        end else if (byte_q == 8'hF0) begin
                            state <= StBrk;
                        end
                    end
                    StExt: begin
                        if (byte_q == 8'hF0) begin
                            state <= StBrk;
                        end else if (byte_q != 8'hE0) begin
                            state <= StIdle;
                            ext   <= 1'b0;
                        end
                    end
                    StBrk: begin
                        state <= StIdle;
                        ext   <= 1'b0;
                    end
                    default: begin
                        state <= StIdle;
                        ext   <= 1'b0;
                    end
                endcase
            end

            if (do_make) begin
                if (|hit) begin
`ifdef PS2_TRK_REPEAT_EN
                    repeat_evt <= 1'b1;
                    last_code  <= key;
`endif
                end else if (found) begin
                    for (int i = 0; i < int'(NSLOT); i++) begin
                        if (free[i]) begin
                            slot[i]       <= key;
                            held_valid[i] <= 1'b1;
                        end
                    end
                    press_evt   <= 1'b1;
                    press_count <= press_count + 1'b1;
                    last_code   <= key;
                end else begin
                    drop_flag <= 1'b1;
                end
            end

            if (do_rel && (|hit)) begin
                for (int i = 0; i < int'(NSLOT); i++) begin
                    if (hit[i]) begin
                        slot[i]       <= '0;
                        held_valid[i] <= 1'b0;
                    end
                end
                release_evt <= 1'b1;
                last_code   <= key;
            end
        end
    end

`ifndef PS2_TRK_REPEAT_EN
    assign repeat_evt = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker (NSLOT=4, CNT_W=4) with hand-computed expectations.
module tb_ps2_key_tracker;
    localparam int unsigned NSLOT = 4;
    localparam int unsigned CNT_W = 4;

    logic               clk = 1'b0;
    logic               clrn = 1'b1;
    logic [7:0]         ps2_data = 8'h00;
    logic               ps2_ready = 1'b0;
    logic               nextdata_n;
    logic               press_evt;
    logic               release_evt;
    logic               repeat_evt;
    logic [8:0]         last_code;
    logic [9*NSLOT-1:0] held_codes;
    logic [NSLOT-1:0]   held_valid;
    logic [CNT_W-1:0]   press_count;
    logic               drop_flag;

    int n_chk  = 0;
    int n_pass = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_rep   = 0;
    int exp_rep;

    ps2_key_tracker #(.NSLOT(NSLOT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .nextdata_n(nextdata_n), .press_evt(press_evt), .release_evt(release_evt),
        .repeat_evt(repeat_evt), .last_code(last_code), .held_codes(held_codes),
        .held_valid(held_valid), .press_count(press_count), .drop_flag(drop_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_evt)   n_press++;
        if (release_evt) n_rel++;
        if (repeat_evt)  n_rep++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!nextdata_n && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check("pop_wait_timeout", 64'd0, 64'd1);
        ps2_data  = b;
        ps2_ready = 1'b1;
        @(posedge clk);
        #1 ps2_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
`ifdef PS2_TRK_REPEAT_EN
        exp_rep = 2;
`else
        exp_rep = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk) clrn = 1'b0;
        #1;
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_held_valid", held_valid, 0);
        check("rst_held_codes", held_codes, 0);
        check("rst_count", press_count, 0);
        check("rst_drop", drop_flag, 0);
        check("rst_last", last_code, 0);
        check("rst_pulses", {press_evt, release_evt, repeat_evt}, 0);

        // first byte with explicit cycle-by-cycle latency checks
        @(negedge clk);
        ps2_data  = 8'h1C;
        ps2_ready = 1'b1;
        @(posedge clk);
        #1 ps2_ready = 1'b0;
        check("lat_pop_low", nextdata_n, 0);
        check("lat_no_evt_t1", press_evt, 0);
        @(posedge clk);
        #1;
        check("lat_pop_high", nextdata_n, 1);
        check("lat_press_t2", press_evt, 1);
        check("mk1c_valid", held_valid, 4'b0001);
        check("mk1c_slot0", held_codes, {27'd0, 9'h01C});
        check("mk1c_count", press_count, 1);
        check("mk1c_last", last_code, 9'h01C);
        @(posedge clk);
        #1;
        check("press_one_cycle", press_evt, 0);
        @(negedge clk);
        #1;

        send(8'hF0); send(8'h1C);
        check("rel1c_cnt", n_rel, 1);
        check("rel1c_valid", held_valid, 0);
        check("rel1c_codes", held_codes, 0);

        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check("rep_presses", n_press, 2);
        check("rep_count", press_count, 2);
        check("rep_repeats", n_rep, exp_rep);
        check("rep_valid", held_valid, 0);

        send(8'hE0); send(8'h75);
        check("ext_slot0", held_codes, {27'd0, 9'h175});
        check("ext_last", last_code, 9'h175);
        send(8'hF0); send(8'h75);
        check("plain_rel_ignored", held_valid, 4'b0001);
        check("plain_rel_no_evt", n_rel, 2);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_rel_valid", held_valid, 0);
        check("ext_rel_cnt", n_rel, 3);
        check("ext_rel_last", last_code, 9'h175);

        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h2B);
        check("full_valid", held_valid, 4'b1111);
        check("full_drop", drop_flag, 1);
        check("full_count", press_count, 7);
        check("full_codes", held_codes, {9'h023, 9'h021, 9'h032, 9'h01C});
        send(8'hF0); send(8'h32);
        check("hole_valid", held_valid, 4'b1101);
        check("hole_codes", held_codes, {9'h023, 9'h021, 9'h000, 9'h01C});
        send(8'h2B);
        check("fill_codes", held_codes, {9'h023, 9'h021, 9'h02B, 9'h01C});
        check("fill_count", press_count, 8);

        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h21);
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h2B);
        check("all_rel_valid", held_valid, 0);
        check("drop_sticky", drop_flag, 1);

        for (int i = 0; i < 8; i++) begin
            send(8'h15 + 8'(i)); send(8'hF0); send(8'h15 + 8'(i));
            if (i == 6) check("count_15", press_count, 15);
        end
        check("count_wrap", press_count, 0);
        check("wrap_releases", n_rel, 16);

        send(8'hAA); send(8'hE1);
        check("discard_count", press_count, 0);
        check("discard_last", last_code, 9'h01C);
        check("discard_valid", held_valid, 0);
        repeat (4) @(negedge clk);
        check("idle_no_pop", nextdata_n, 1);

        send(8'hE0); send(8'hF0);
        @(negedge clk) clrn = 1'b1;
        #1;
        check("midrst_outputs",
              {nextdata_n, press_evt, release_evt, repeat_evt, drop_flag}, 5'b10000);
        check("midrst_state", {last_code, held_codes, held_valid, press_count}, 0);
        @(negedge clk) clrn = 1'b0;
        send(8'h1C);
        check("post_rst_make", held_codes, {27'd0, 9'h01C});
        check("post_rst_count", press_count, 1);
        check("post_rst_no_rel", n_rel, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
